// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even parity, SB_TICK-tick stop.
// Define UART_TX_PARITY_EN to compile in the even-parity bit between DATA and STOP.
module uart_tx #(
  parameter int NB_DATA     = 8,
  parameter int SB_TICK     = 16,
  parameter int NB_TICK_CNT = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_TICK_CNT-1:0] BIT_LAST  = NB_TICK_CNT'(15);
  localparam logic [NB_TICK_CNT-1:0] STOP_LAST = NB_TICK_CNT'(SB_TICK - 1);
  localparam logic [NB_BIT_CNT-1:0]  N_LAST    = NB_BIT_CNT'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state, state_next;
  logic [NB_TICK_CNT-1:0] s, s_next;
  logic [NB_BIT_CNT-1:0]  n, n_next;
  logic [NB_DATA-1:0]     b, b_next;
  logic                   tx_next, busy_next, done_next;
`ifdef UART_TX_PARITY_EN
  logic                   p, p_next;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      p         <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      s         <= s_next;
      n         <= n_next;
      b         <= b_next;
      o_tx      <= tx_next;
      o_busy    <= busy_next;
      o_tx_done <= done_next;
`ifdef UART_TX_PARITY_EN
      p         <= p_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_next     = p;
`endif
    case (state)
      IDLE: begin
        // A tick in the accepting cycle is deliberately not counted.
        if (i_tx_start) begin
          b_next     = i_data;
          s_next     = '0;
          n_next     = '0;
`ifdef UART_TX_PARITY_EN
          p_next     = 1'b0;
`endif
          state_next = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s == BIT_LAST) begin
            s_next = '0;
            b_next = b >> 1;
`ifdef UART_TX_PARITY_EN
            p_next = p ^ b[0];
            if (n == N_LAST) state_next = PARITY;
            else             n_next     = n + 1'b1;
`else
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 1'b1;
`endif
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (s == STOP_LAST) begin
            s_next     = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = p_next;
`endif
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued at each request and popped mid-bit.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * 16 * 4;

  logic       clk = 1'b0;
  logic       rst, tick, start;
  logic [7:0] data;
  logic       tx, busy, done;

  int   passed = 0, total = 0, fails = 0;
  int   cyc = 0, done_cnt = 0, tcnt = 0;
  int   acc_cyc, done_at, d0, bad;
  bit   found, drop_start;
  logic exp_q[$];

  uart_tx #(.NB_DATA(8), .SB_TICK(16), .NB_TICK_CNT(5)) dut (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx), .o_busy(busy), .o_tx_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Oversampling tick every 4 clks, driven away from the active edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % 4;
      tick = (tcnt == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic wait_ticks(input int nt);
    int k = 0;
    while (k < nt) begin
      @(posedge clk);
      if (tick) k++;
      if (drop_start) begin
        #1;
        start      = 1'b0;
        drop_start = 1'b0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input bit push);
    data  = d;
    start = 1'b1;
    if (push) push_frame(d);
    @(posedge clk);
    #1;
    start   = 1'b0;
    acc_cyc = cyc;
    @(negedge clk);
    check("start_tx_low", tx, 1'b0);
    check("start_busy", busy, 1'b1);
  endtask

  task automatic capture(input int inject_bit);
    logic e;
    wait_ticks(8);
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i > 0) wait_ticks(16);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bz;
      check($sformatf("bit%0d", i), tx, e);
      if (i == inject_bit) begin
        start      = 1'b1;
        data       = 8'hC3;
        drop_start = 1'b1;
      end
    end
    check("sb_drained", exp_q.size(), 0);
  endtask

  // Returns at the negedge of the o_tx_done cycle.
  task automatic end_frame();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found   = 1'b1;
        done_at = cyc;
      end
    end
    check("done_seen", found, 1'b1);
    check("busy_len_ok", ((done_at - acc_cyc) >= FRAME_CLKS - 4) &&
                         ((done_at - acc_cyc) <= FRAME_CLKS + 4), 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("tx_at_done", tx, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] d, input int inject_bit);
    d0 = done_cnt;
    send(d, 1'b1);
    capture(inject_bit);
    end_frame();
    @(negedge clk);
    check("done_one_clk", done, 1'b0);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = 8'h00; drop_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
    end
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_1000", bad, 0);

    run_frame(8'hA5, -1);

    // Back-to-back: second request raised in the o_tx_done cycle.
    send(8'h00, 1'b1);
    capture(-1);
    end_frame();
    send(8'hFF, 1'b1);
    capture(-1);
    end_frame();
    @(negedge clk);
    check("b2b_done_one_clk", done, 1'b0);

    // Second request (8'hC3) lands mid-DATA and must be ignored.
    run_frame(8'h3C, 3);
    repeat (40) @(negedge clk);
    check("ignore_idle", busy, 1'b0);
    check("ignore_one_done", done_cnt - d0, 1);

    // Reset at tick 70 aborts the frame silently.
    send(8'h5A, 1'b0);
    wait_ticks(70);
    @(negedge clk);
    rst = 1'b1;
    d0  = done_cnt;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_frame(8'h96, -1);

    // Reset and start together: nothing is captured.
    rst = 1'b1; start = 1'b1; data = 8'h55;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", busy, 1'b0);
    check("rst_start_tx", tx, 1'b1);

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, -1);
    run_frame(8'h03, -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
